// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multi-cycle datapath control FSM
//
// Sequences the shared ALU, register file, unified memory port, PC/IR and
// immediate extender over 3-5 cycles per instruction.
//
// Ports:
//   clk, reset_n         rising-edge clock, asynchronous active-low reset
//   op, funct3, funct7b5 decoded fields of the registered instruction
//   zero, lt, ltu        ALU flags used for branch resolution
//   mem_ready            memory access completes this cycle
//   PCWrite, IRWrite     PC / IR+OldPC enables
//   AdrSrc, MemWrite     memory address select and write strobe
//   ResultSrc            00 ALUOut, 01 ReadData, 10 ALUResult
//   ALUSrcA / ALUSrcB    ALU operand selects
//   ALUControl           ALU operation
//   RegWrite, ImmSrc     register write enable, immediate format
//   retire, illegal      end-of-instruction / unsupported-instruction pulses
//
// Build option: FULL_BRANCH_EN enables blt/bge/bltu/bgeu.

module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic       RegWrite,
  output logic [2:0] ImmSrc,
  output logic       retire,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_JALR, S_JAL, S_LUI, S_AUIPC, S_BRANCH
  } state_t;

  state_t     state, next_state;
  logic [3:0] alu_fn;
  logic       br_legal;
  logic       br_taken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next_state;
  end

  always_comb begin
    case (op)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

  // Only R-type (op[5]=1) may turn funct3=000 into sub; addi ignores bit 30.
  always_comb begin
    case (funct3)
      3'b000:  alu_fn = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  end

`ifdef FULL_BRANCH_EN
  assign br_legal = (funct3[2:1] != 2'b01);
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = !ltu;
      default: br_taken = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign unused_flags = lt | ltu;
  assign br_legal = (funct3[2:1] == 2'b00);
  assign br_taken = funct3[0] ? !zero : zero;
`endif

  always_comb begin
    next_state = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    RegWrite   = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_IMM:            next_state = S_EXECI;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI:            next_state = S_LUI;
          OP_AUIPC:          next_state = S_AUIPC;
          OP_BRANCH: begin
            if (br_legal) next_state = S_BRANCH;
            else begin
              illegal    = 1'b1;
              next_state = S_FETCH;
            end
          end
          default: begin
            illegal    = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ready;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_fn;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_fn;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = S_JAL;
      end
      // Target already sits in ALUOut; ALU computes OldPC+4 for rd.
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        next_state = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA    = 2'b11;
        ALUSrcB    = 2'b01;
        next_state = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        next_state = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = br_taken;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase

    // Enables must drop the instant reset asserts, not at the next edge.
    if (!reset_n) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
